// File: rtl/vending_pkg.sv
// Shared types, error codes and price lookup for the N-item vending controller.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INSUFF  = 2'b01;
    localparam logic [1:0] ERR_SOLDOUT = 2'b10;
    localparam logic [1:0] ERR_COIN    = 2'b11;

    localparam int unsigned PRICE_VEC_MAX = 512;

    // Extracts the w-bit price of item idx from a packed price vector.
    function automatic logic [31:0] price_at(input logic [PRICE_VEC_MAX-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [PRICE_VEC_MAX-1:0] sh;
        sh       = prices >> (idx * w);
        price_at = '0;
        for (int unsigned b = 0; b < 32; b++) begin
            if (b < w) price_at[b] = sh[b];
        end
    endfunction

endpackage

// File: rtl/vending_machine_n_items_stock.sv
// Per-item stock counters with restock, guarded decrement and registered sold_out vector.
module vend_stock_bank
    import vending_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 5,
    localparam int unsigned SEL_W     = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restock,
    input  logic                 dec_en,
    input  logic [SEL_W-1:0]     dec_idx,
    output logic [NUM_ITEMS-1:0] sold_out
);

    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

    // Restock overrides a same-cycle decrement so stock lands on INIT_STOCK.
    always_comb begin
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (dec_en && (32'(dec_idx) == i) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            if (restock) stock_d[i] = STOCK_W'(INIT_STOCK);
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
            sold_out_q <= {NUM_ITEMS{STOCK_W'(INIT_STOCK) == '0}};
        end else begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;

endmodule

// File: rtl/vending_machine_n_items.sv
// Parametrised N-item vending controller with credit, refund and per-item stock.
// Optional audit counters (sales_total, vend_count) enabled by VM_AUDIT_COUNT_EN.
module vending_machine_n_items
    import vending_pkg::*;
#(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned INIT_STOCK = 5,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] ITEM_PRICES = {8'd50, 8'd20, 8'd10, 8'd5},
    localparam int unsigned SEL_W     = $clog2(NUM_ITEMS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [CREDIT_W-1:0]  coin_in,
    input  logic                 sel_valid,
    input  logic [SEL_W-1:0]     select,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 out,
    output logic [NUM_ITEMS-1:0] item_dispensed,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic [1:0]           err_pulse,
`ifdef VM_AUDIT_COUNT_EN
    output logic [31:0]          sales_total,
    output logic [15:0]          vend_count,
`endif
    output logic                 busy
);

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d, change_q, change_d, price_c;
    logic [SEL_W-1:0]     vend_sel_q, vend_sel_d;
    logic [NUM_ITEMS-1:0] item_q, item_d, sold_out_w;
    logic [1:0]           err_q, err_d;
    logic                 out_q, out_d, change_valid_q, change_valid_d, busy_q, busy_d;
    logic                 dec_en;
    logic [CREDIT_W:0]    coin_sum;
    logic                 accepting, coin_nz, cancel_ok, sel_bad, sel_insuff, sel_go, coin_fits;

    // Front-end decode; priority is cancel > select > coin.
    assign accepting  = (state_q == IDLE) || (state_q == CREDIT);
    assign coin_nz    = coin_valid && (coin_in != '0);
    assign price_c    = CREDIT_W'(price_at(PRICE_VEC_MAX'(ITEM_PRICES), 32'(select), CREDIT_W));
    assign cancel_ok  = cancel && (credit_q != '0);
    assign sel_bad    = !cancel_ok && sel_valid &&
                        ((32'(select) >= NUM_ITEMS) || sold_out_w[select]);
    assign sel_insuff = !cancel_ok && sel_valid && !sel_bad && (credit_q < price_c);
    assign sel_go     = !cancel_ok && sel_valid && !sel_bad && !sel_insuff;
    assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_in};
    assign coin_fits  = !coin_sum[CREDIT_W];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, CREDIT: begin
                if (cancel_ok)                            state_d = CHANGE;
                else if (sel_go)                          state_d = VEND;
                else if (!sel_valid && coin_nz && coin_fits) state_d = CREDIT;
            end
            VEND:   state_d = CHANGE;
            CHANGE: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; strobes are set one edge ahead so they align with the state.
    always_comb begin
        out_d          = 1'b0;
        item_d         = '0;
        change_valid_d = 1'b0;
        change_d       = '0;
        credit_d       = credit_q;
        err_d          = ERR_NONE;
        vend_sel_d     = vend_sel_q;
        dec_en         = 1'b0;
        busy_d         = (state_d == VEND) || (state_d == CHANGE);
        if (accepting) begin
            if (cancel_ok) begin
                change_valid_d = 1'b1;
                change_d       = credit_q;
                credit_d       = '0;
                if (coin_nz) err_d = ERR_COIN;
            end else if (sel_bad) begin
                err_d = ERR_SOLDOUT;
            end else if (sel_insuff) begin
                err_d = ERR_INSUFF;
            end else if (sel_go) begin
                out_d      = 1'b1;
                item_d     = NUM_ITEMS'(1) << select;
                credit_d   = credit_q - price_c;
                vend_sel_d = select;
                if (coin_nz) err_d = ERR_COIN;
            end else if (coin_nz) begin
                if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
                else           err_d    = ERR_COIN;
            end
        end else begin
            if (coin_nz) err_d = ERR_COIN;
            if (state_q == VEND) begin
                dec_en         = 1'b1;
                change_valid_d = 1'b1;
                change_d       = credit_q;
                credit_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q          <= 1'b0;
            item_q         <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            credit_q       <= '0;
            err_q          <= ERR_NONE;
            busy_q         <= 1'b0;
            vend_sel_q     <= '0;
        end else begin
            out_q          <= out_d;
            item_q         <= item_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            credit_q       <= credit_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            vend_sel_q     <= vend_sel_d;
        end
    end

`ifdef VM_AUDIT_COUNT_EN
    logic [CREDIT_W-1:0] vend_price_q;
    logic [31:0]         sales_total_q;
    logic [15:0]         vend_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vend_price_q  <= '0;
            sales_total_q <= '0;
            vend_count_q  <= '0;
        end else begin
            if (accepting && sel_go) vend_price_q <= price_c;
            if (state_q == VEND) begin
                sales_total_q <= sales_total_q + 32'(vend_price_q);
                vend_count_q  <= vend_count_q + 16'd1;
            end
        end
    end

    assign sales_total = sales_total_q;
    assign vend_count  = vend_count_q;
`endif

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .rst      (rst),
        .restock  (restock),
        .dec_en   (dec_en),
        .dec_idx  (vend_sel_q),
        .sold_out (sold_out_w)
    );

    assign out            = out_q;
    assign item_dispensed = item_q;
    assign change_valid   = change_valid_q;
    assign change         = change_q;
    assign credit         = credit_q;
    assign sold_out       = sold_out_w;
    assign err_pulse      = err_q;
    assign busy           = busy_q;

endmodule
